// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the program loader, the instruction memory port and imem_arbiter.
// The slave modport is the arbiter's view of the bundle; master is the surrounding environment.
interface imem_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        f_err;
  logic        stall;
  logic        l_req;
  logic        l_lock;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        mem_en;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  f_req, f_addr, l_req, l_lock, l_addr, l_wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, f_err, stall, l_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, l_req, l_lock, l_addr, l_wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, f_err, stall, l_gnt,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: fetch vs. loader, with burst lock and fetch starvation override.
// Optional IMEM_ARB_RR_EN: round-robin between fetch and loader on IDLE contention.
module imem_arbiter #(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  imem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned ADDR_W = 10;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             force_f;
  logic             f_gnt_c;
  logic             l_gnt_c;
  logic             f_rvalid_q;
  logic             f_err_q;
`ifdef IMEM_ARB_RR_EN
  logic             last_f;
`endif

  // Address bits above the 4 KiB window and the loader byte offset are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.f_addr[31:12], bus.l_addr[31:12], bus.l_addr[1:0]};

  assign force_f = bus.f_req && (starve_cnt >= STARVE_LIM);

  // Grant decision: starvation override, then lock, then loader priority (or round-robin).
  always_comb begin
    f_gnt_c = 1'b0;
    l_gnt_c = 1'b0;
    if (force_f) begin
      f_gnt_c = 1'b1;
    end else if (state == LOCKED) begin
      l_gnt_c = bus.l_req;
    end else begin
`ifdef IMEM_ARB_RR_EN
      if (bus.l_req && bus.f_req) begin
        l_gnt_c = last_f;
        f_gnt_c = ~last_f;
      end else begin
        l_gnt_c = bus.l_req;
        f_gnt_c = bus.f_req;
      end
`else
      l_gnt_c = bus.l_req;
      f_gnt_c = bus.f_req && !bus.l_req;
`endif
    end
  end

  assign bus.f_gnt     = f_gnt_c;
  assign bus.l_gnt     = l_gnt_c;
  assign bus.stall     = bus.f_req && !f_gnt_c;
  assign bus.mem_en    = f_gnt_c || l_gnt_c;
  assign bus.mem_we    = l_gnt_c;
  assign bus.mem_addr  = l_gnt_c ? bus.l_addr[11:2] :
                         f_gnt_c ? bus.f_addr[11:2] : ADDR_W'(0);
  assign bus.mem_wdata = l_gnt_c ? bus.l_wdata : 32'd0;
  assign bus.f_rdata   = bus.mem_rdata;
  assign bus.f_rvalid  = f_rvalid_q;
  assign bus.f_err     = f_err_q;

  // Lock state, starvation counter and read-response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      f_rvalid_q <= 1'b0;
      f_err_q    <= 1'b0;
    end else begin
      f_rvalid_q <= f_gnt_c;
      f_err_q    <= f_gnt_c && (bus.f_addr[1:0] != 2'b00);

      if (f_gnt_c || !bus.f_req) starve_cnt <= '0;
      else                       starve_cnt <= starve_cnt + CNT_W'(1);

      case (state)
        IDLE:    if (bus.l_lock && l_gnt_c) state <= LOCKED;
        LOCKED:  if (!bus.l_lock)           state <= IDLE;
        default:                            state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_ARB_RR_EN
  // Last winner starts as fetch so the loader takes the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       last_f <= 1'b1;
    else if (f_gnt_c) last_f <= 1'b1;
    else if (l_gnt_c) last_f <= 1'b0;
  end
`endif

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Single-port arbiter and sequencer for the 1024-word instruction memory. It shares the memory's one access port between two requesters: the core's fetch stage (read-only) and the program loader (write, used for in-system program download). It converts byte addresses to word indices, returns read data one cycle after grant, and raises a stall to the core whenever fetch is denied. It also guarantees fetch forward progress with a starvation limit.

## Interface
- STARVE_MAX, default 8: consecutive denied fetch cycles after which fetch is force-granted (1..255).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- f_req  in  1  fetch request, level; held until f_gnt.
- f_addr  in  32  fetch byte address.
- f_gnt  out  1  fetch granted this cycle (combinational).
- f_rvalid  out  1  f_rdata valid (registered, one cycle after f_gnt).
- f_rdata  out  32  fetched instruction.
- f_err  out  1  misaligned fetch (f_addr[1:0]≠0); qualified by f_rvalid.
- stall  out  1  f_req & ~f_gnt.
- l_req  in  1  loader write request.
- l_lock  in  1  loader burst lock; while set and held, fetch is blocked except by starvation override.
- l_addr  in  32  loader byte address.
- l_wdata  in  32  loader write data.
- l_gnt  out  1  loader write granted this cycle (combinational).
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  10  word index.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  synchronous read data, valid the cycle after mem_en & ~mem_we.

## Operation
- Word index is addr[11:2]. Bits [31:12] are ignored, so addresses alias modulo 4 KiB.
- Misaligned fetch is still performed at addr[11:2]. f_err is registered alongside f_rvalid. Misaligned loader writes are performed at addr[11:2] with no error.
- States: IDLE, LOCKED.
  - IDLE→LOCKED when l_lock & l_gnt.
  - LOCKED→IDLE when ~l_lock.
- Default arbitration: the loader has priority. l_req wins over f_req.
- In LOCKED, f_gnt is 0 even when l_req is low, unless the starvation override fires.
- Starvation counter (8-bit):
  - Increments each cycle that stall=1.
  - Clears on f_gnt or when f_req=0.
  - When it reaches STARVE_MAX, the next cycle with f_req grants fetch regardless of l_req or state. l_gnt is 0 that cycle, and the counter clears.
- At most one grant per cycle. The port is driven only on a grant:
  - mem_en = f_gnt | l_gnt.
  - mem_we = l_gnt.
  - mem_addr and mem_wdata come from the winner.
  - With no grant, mem_en=0 and the other memory outputs are don't-care (drive 0).
- Read-after-write to the same word: a fetch granted the cycle after a loader write returns the new data (memory is write-first). The arbiter adds no forwarding.

## Timing
- Grant latency: 0 cycles. f_gnt and l_gnt are combinational from requests, state and counter.
- Fetch data latency: exactly 1 cycle. f_rvalid is high in cycle N+1 iff f_gnt in cycle N. f_rdata = mem_rdata is passed through, valid only with f_rvalid.
- Back-to-back fetch grants give one f_rvalid per cycle.
- Reset values: state=IDLE, starvation counter=0, f_rvalid=0, f_err=0. All combinational outputs are 0 while requests are low.
- Reset mid-burst drops to IDLE and loses the lock. A pending f_rvalid is cleared. The loader must re-assert l_lock.
- Simultaneous l_req & f_req in IDLE with counter<STARVE_MAX: l_gnt=1, f_gnt=0, stall=1.
- Dropping l_lock and asserting f_req in the same cycle: state is still LOCKED, so f_gnt=0 (unless overridden). Fetch is granted the next cycle at the earliest.

## Configuration
- IMEM_ARB_RR_EN defined: when both requests contend in IDLE, the grant alternates round-robin. A 1-bit last-winner register is reset to "fetch", so the loader wins the first contention. LOCKED behaviour and the starvation override are unchanged.
- IMEM_ARB_RR_EN undefined: fixed loader priority as above, and no last-winner register exists.

## Test plan
- Reset, then f_req with f_addr=0x0000_0010 and memory word 4=0x2402_0001 → f_gnt same cycle, mem_addr=4; next cycle f_rvalid=1, f_rdata=0x2402_0001, f_err=0.
- f_addr=0x0000_1006 → mem_addr=1, f_err=1 with f_rvalid.
- Loader writes 0xDEAD_BEEF to 0x20 while f_req is held on 0x20 → l_gnt, mem_we=1, stall=1; next cycle f_gnt, and the following cycle f_rdata=0xDEAD_BEEF.
- l_lock held with continuous l_req and STARVE_MAX=8 (macro undefined) → stall for 8 cycles, forced f_gnt on cycle 9 with l_gnt=0, then the loader resumes.
- IMEM_ARB_RR_EN defined, both requesting continuously in IDLE → grants alternate L,F,L,F; f_rvalid follows each F by 1 cycle.
- rst_n pulsed low for 1 cycle mid-burst in LOCKED with a fetch pending rvalid → f_rvalid=0 immediately. After release, l_lock low and f_req high → f_gnt=1 in the first cycle.
